strip_tx_sequencer: RTL and testbench

//  Sequences transmission of one full LED-strip refresh: walks the LED index 0..N_LEDS-1,

---
 rtl/strip_tx_sequencer_if.sv | 46 ++++
 rtl/strip_tx_sequencer.sv | 169 ++++++++++++++++
 tb/tb_strip_tx_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/strip_tx_sequencer_if.sv
// ---------------------------------------------------------------------------
// strip_tx_sequencer_if
//   Bundles the signals between the LED-strip refresh sequencer, the
//   render-side requester and the external frame mux.
//   Signals:
//     start     render side -> sequencer  refresh request
//     frame_in  frame mux   -> sequencer  24-bit frame of the LED on led_idx
//     led_idx   sequencer   -> frame mux  LED currently selected/transmitted
//     dout      sequencer   -> strip pin  one-wire serial data
//     busy      sequencer   -> render     high whenever a refresh is in flight
//     done      sequencer   -> render     one-cycle pulse on the final latch cycle
//   Modports:
//     master  render/mux side (drives start and frame_in)
//     slave   sequencer side  (drives led_idx, dout, busy, done)
// ---------------------------------------------------------------------------
interface strip_tx_sequencer_if #(
  parameter int N_LEDS = 8,
  parameter int BITS   = 24
);

  logic                      start;
  logic [BITS-1:0]           frame_in;
  logic [$clog2(N_LEDS)-1:0] led_idx;
  logic                      dout;
  logic                      busy;
  logic                      done;

  modport master (
    output start,
    output frame_in,
    input  led_idx,
    input  dout,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  frame_in,
    output led_idx,
    output dout,
    output busy,
    output done
  );

endinterface

// File: rtl/strip_tx_sequencer.sv
// ---------------------------------------------------------------------------
// strip_tx_sequencer
//   Runs one complete WS2812-style strip refresh per accepted start request:
//   walks LED 0..N_LEDS-1, captures each LED's frame from the external mux
//   (led_idx -> frame_in), shifts it out MSB first as high/low pulse pairs of
//   exactly TBIT cycles, and closes the refresh with a TRES-cycle low latch.
//   Ports:
//     clk   in   rising-edge clock
//     rst   in   asynchronous reset, active high (aborts any refresh)
//     bus   slave modport of strip_tx_sequencer_if
//           start (in), frame_in (in), led_idx (out), dout (out),
//           busy (out), done (out) -- all outputs come straight from flops.
//   Timing notes:
//     dout is a registered copy of "FSM is in HIGH", so the line lags the
//     state by one cycle: start sampled at edge k gives LOAD during k..k+1,
//     HIGH from k+1, and the pin rises at edge k+2. Every bit period on the
//     pin is exactly TBIT cycles; the first LOAD of a refresh is the only
//     extra low cycle.
// ---------------------------------------------------------------------------
module strip_tx_sequencer #(
  parameter int N_LEDS = 8,
  parameter int BITS   = 24,
  parameter int T0H    = 20,
  parameter int T1H    = 40,
  parameter int TBIT   = 63,
  parameter int TRES   = 3000
) (
  input  logic                clk,
  input  logic                rst,
  strip_tx_sequencer_if.slave bus
);

  localparam int LW   = $clog2(N_LEDS);
  localparam int BCW  = $clog2(BITS);
  // One timer serves the bit phases and the latch; size it for the longer.
  localparam int TMAX = (TRES > TBIT) ? TRES : TBIT;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_LATCH = 3'd4
  } state_t;

  state_t           r_state;
  logic [BITS-1:0]  r_shreg;
  logic [BCW-1:0]   r_bit_cnt;
  logic [TW-1:0]    r_timer;
  logic [LW-1:0]    r_led_idx;
  logic             r_dout;
  logic             r_busy;
  logic             r_done;

  logic             w_timer_zero;
  logic             w_last_bit;
  logic             w_last_led;
  logic             w_next_msb;

  // Timer reload for a HIGH phase: the timer counts down to zero, so a phase
  // of n cycles is loaded with n-1.
  function automatic logic [TW-1:0] f_high_reload(input logic bit_val);
    f_high_reload = bit_val ? TW'(T1H - 1) : TW'(T0H - 1);
  endfunction

  // Timer reload for a LOW phase. When the next LED's LOAD cycle will follow,
  // that LOAD is the last low cycle of this bit, so LOW gives up one cycle.
  function automatic logic [TW-1:0] f_low_reload(input logic bit_val,
                                                 input logic shorten);
    logic [TW-1:0] v_len;
    v_len = bit_val ? TW'(TBIT - T1H - 1) : TW'(TBIT - T0H - 1);
    f_low_reload = shorten ? (v_len - TW'(1)) : v_len;
  endfunction

  assign w_timer_zero = (r_timer == {TW{1'b0}});
  assign w_last_bit   = (r_bit_cnt == BCW'(BITS - 1));
  assign w_last_led   = (r_led_idx == LW'(N_LEDS - 1));
  // MSB after the next left shift, i.e. the value of the upcoming bit.
  assign w_next_msb   = r_shreg[BITS-2];

  // Refresh state machine with all outputs registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_shreg   <= {BITS{1'b0}};
      r_bit_cnt <= {BCW{1'b0}};
      r_timer   <= {TW{1'b0}};
      r_led_idx <= {LW{1'b0}};
      r_dout    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      // The pin follows the state one cycle later and never glitches.
      r_dout <= (r_state == S_HIGH);

      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          r_busy <= bus.start;
          if (bus.start) begin
            r_state   <= S_LOAD;
            r_led_idx <= {LW{1'b0}};
          end
        end

        S_LOAD: begin
          // frame_in reflects the led_idx set on entry to this cycle.
          r_shreg   <= bus.frame_in;
          r_bit_cnt <= {BCW{1'b0}};
          r_timer   <= f_high_reload(bus.frame_in[BITS-1]);
          r_state   <= S_HIGH;
        end

        S_HIGH: begin
          if (w_timer_zero) begin
            r_timer <= f_low_reload(r_shreg[BITS-1], w_last_bit && !w_last_led);
            r_state <= S_LOW;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end

        S_LOW: begin
          if (!w_timer_zero) begin
            r_timer <= r_timer - TW'(1);
          end else if (!w_last_bit) begin
            r_shreg   <= {r_shreg[BITS-2:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + BCW'(1);
            r_timer   <= f_high_reload(w_next_msb);
            r_state   <= S_HIGH;
          end else if (!w_last_led) begin
            r_led_idx <= r_led_idx + LW'(1);
            r_state   <= S_LOAD;
          end else begin
            // led_idx deliberately holds N_LEDS-1 through the latch.
            r_timer <= TW'(TRES - 1);
            r_done  <= (TRES == 1) ? 1'b1 : 1'b0;
            r_state <= S_LATCH;
          end
        end

        S_LATCH: begin
          if (w_timer_zero) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end else begin
            r_timer <= r_timer - TW'(1);
            // Raise done so it lines up with the final latch cycle.
            r_done  <= (r_timer == TW'(1));
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.led_idx = r_led_idx;
  assign bus.dout    = r_dout;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;

endmodule

// File: tb/tb_strip_tx_sequencer.sv
// ---------------------------------------------------------------------------
// tb_strip_tx_sequencer
//   Two sequencer instances share one clock and reset: dut_a with default
//   timing (full-size refresh) and dut_b with short timing (N_LEDS=2,
//   T0H=2, T1H=4, TBIT=7, TRES=10). Expected pin waveforms are generated
//   from the frame values as plain pulse trains and compared cycle by cycle.
// ---------------------------------------------------------------------------
module tb_strip_tx_sequencer;

  localparam int BITS   = 24;
  localparam int A_N    = 8;
  localparam int A_T0H  = 20;
  localparam int A_T1H  = 40;
  localparam int A_TBIT = 63;
  localparam int A_TRES = 3000;
  localparam int B_N    = 2;
  localparam int B_T0H  = 2;
  localparam int B_T1H  = 4;
  localparam int B_TBIT = 7;
  localparam int B_TRES = 10;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  strip_tx_sequencer_if #(.N_LEDS(A_N), .BITS(BITS)) bus_a ();
  strip_tx_sequencer_if #(.N_LEDS(B_N), .BITS(BITS)) bus_b ();

  logic [BITS-1:0] frames_a [A_N];
  logic [BITS-1:0] frames_b [B_N];

  // External combinational frame muxes.
  always_comb bus_a.frame_in = frames_a[bus_a.led_idx];
  always_comb bus_b.frame_in = frames_b[bus_b.led_idx];

  strip_tx_sequencer #(.N_LEDS(A_N), .BITS(BITS), .T0H(A_T0H), .T1H(A_T1H),
                       .TBIT(A_TBIT), .TRES(A_TRES))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  strip_tx_sequencer #(.N_LEDS(B_N), .BITS(BITS), .T0H(B_T0H), .T1H(B_T1H),
                       .TBIT(B_TBIT), .TRES(B_TRES))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model state.
  logic [BITS-1:0] exp_frames [8];
  bit              w[$];          // ideal line level, index 0 = first LOAD cycle
  int              rise_c[$];
  int              width_q[$];
  int              pulse_q[$];
  int              mut_c[$];
  int              mut_idx[$];
  logic [BITS-1:0] mut_val[$];
  int              done_c;
  int              done_cyc;
  int              load_cyc;
  int              busy_cnt;

  // Build the ideal waveform: 1 load gap, then every bit as T_H high followed
  // by TBIT-T_H low, then TRES low latch cycles.
  function automatic void build_model(input int n, input int t0h, input int t1h,
                                      input int tbit, input int tres);
    w.delete();
    w.push_back(1'b0);
    for (int j = 0; j < n; j++) begin
      for (int b = BITS - 1; b >= 0; b--) begin
        int h;
        h = exp_frames[j][b] ? t1h : t0h;
        for (int t = 0; t < tbit; t++) w.push_back(t < h);
      end
    end
    for (int t = 0; t < tres; t++) w.push_back(1'b0);
  endfunction

  function automatic bit in_pulse(input int c);
    foreach (pulse_q[i]) if (pulse_q[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) bus_a.start = v;
    else          bus_b.start = v;
  endtask

  task automatic sample(input int sel, output logic d, output logic b,
                        output logic dn, output logic [31:0] li);
    if (sel == 0) begin
      d = bus_a.dout; b = bus_a.busy; dn = bus_a.done; li = 32'(bus_a.led_idx);
    end else begin
      d = bus_b.dout; b = bus_b.busy; dn = bus_b.done; li = 32'(bus_b.led_idx);
    end
  endtask

  // Start one refresh from a negedge and compare every cycle up to and
  // including the first IDLE cycle after it.
  task automatic run_refresh(input int sel, input int n, input int tbit,
                             input bit hold, input string name);
    int          L;
    int          nbad [4];
    int          fc   [4];
    logic [31:0] fg   [4];
    logic [31:0] fw   [4];
    logic [31:0] gv   [4];
    logic [31:0] ev   [4];
    string       sn   [4];
    logic        d, b, dn, prev;
    logic [31:0] li;
    int          rise_at, led;
    sn[0] = "dout"; sn[1] = "busy"; sn[2] = "done"; sn[3] = "led_idx";
    for (int k = 0; k < 4; k++) begin nbad[k] = 0; fc[k] = -1; fg[k] = '0; fw[k] = '0; end
    L = w.size();
    rise_c.delete(); width_q.delete();
    done_c = -1; busy_cnt = 0; prev = 1'b0; rise_at = 0;
    set_start(sel, 1'b1);
    for (int c = 0; c <= L; c++) begin
      @(negedge clk);
      if (c == 0) load_cyc = cyc;
      for (int m = 0; m < mut_c.size(); m++)
        if (mut_c[m] == c) frames_b[mut_idx[m]] = mut_val[m];
      sample(sel, d, b, dn, li);
      led   = (c >= L) ? n - 1 : (((c / (BITS * tbit)) < n - 1) ? c / (BITS * tbit) : n - 1);
      ev[0] = (c >= 1) ? 32'(w[c-1]) : 32'd0;
      ev[1] = (c < L) ? 32'd1 : 32'd0;
      ev[2] = (c == L - 1) ? 32'd1 : 32'd0;
      ev[3] = 32'(led);
      gv[0] = {31'd0, d}; gv[1] = {31'd0, b}; gv[2] = {31'd0, dn}; gv[3] = li;
      for (int k = 0; k < 4; k++) begin
        if (gv[k] !== ev[k]) begin
          nbad[k]++;
          if (fc[k] < 0) begin fc[k] = c; fg[k] = gv[k]; fw[k] = ev[k]; end
        end
      end
      if (d === 1'b1 && prev !== 1'b1) begin rise_at = c; rise_c.push_back(c); end
      if (d !== 1'b1 && prev === 1'b1) width_q.push_back(c - rise_at);
      prev = d;
      if (b === 1'b1) busy_cnt++;
      if (dn === 1'b1 && done_c < 0) begin done_c = c; done_cyc = cyc; end
      if (!hold) set_start(sel, (c < L) && in_pulse(c));
    end
    for (int k = 0; k < 4; k++) begin
      total_cnt++;
      if (nbad[k] !== 0)
        $display("FAIL %s_%s: %0d cycles differ (required 0), first at cycle %0d got %0h required %0h",
                 name, sn[k], nbad[k], fc[k], fg[k], fw[k]);
      else
        pass_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    foreach (frames_a[i]) frames_a[i] = '0;
    foreach (frames_b[i]) frames_b[i] = '0;
    repeat (3) @(negedge clk);
    total_cnt += 8;
    if (bus_a.dout !== 1'b0) $display("FAIL reset_a_dout: got %b required 0", bus_a.dout); else pass_cnt++;
    if (bus_a.busy !== 1'b0) $display("FAIL reset_a_busy: got %b required 0", bus_a.busy); else pass_cnt++;
    if (bus_a.done !== 1'b0) $display("FAIL reset_a_done: got %b required 0", bus_a.done); else pass_cnt++;
    if (bus_a.led_idx !== 3'd0) $display("FAIL reset_a_led_idx: got %0d required 0", bus_a.led_idx); else pass_cnt++;
    if (bus_b.dout !== 1'b0) $display("FAIL reset_b_dout: got %b required 0", bus_b.dout); else pass_cnt++;
    if (bus_b.busy !== 1'b0) $display("FAIL reset_b_busy: got %b required 0", bus_b.busy); else pass_cnt++;
    if (bus_b.done !== 1'b0) $display("FAIL reset_b_done: got %b required 0", bus_b.done); else pass_cnt++;
    if (bus_b.led_idx !== 1'b0) $display("FAIL reset_b_led_idx: got %0d required 0", bus_b.led_idx); else pass_cnt++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Default timing, all frames zero.
  task automatic test_default_zero();
    int bad_w;
    foreach (exp_frames[i]) exp_frames[i] = '0;
    build_model(A_N, A_T0H, A_T1H, A_TBIT, A_TRES);
    run_refresh(0, A_N, A_TBIT, 1'b0, "default_zero");
    bad_w = 0;
    foreach (width_q[i]) if (width_q[i] != A_T0H) bad_w++;
    total_cnt += 4;
    if (rise_c.size() !== A_N * BITS) $display("FAIL zero_pulse_count: got %0d required %0d", rise_c.size(), A_N * BITS); else pass_cnt++;
    if (bad_w !== 0) $display("FAIL zero_pulse_width: %0d pulses not %0d cycles wide (required 0)", bad_w, A_T0H); else pass_cnt++;
    if (done_c + 1 !== 15097) $display("FAIL zero_done_busy_cycle: got %0d required 15097", done_c + 1); else pass_cnt++;
    if (rise_c.size() == 0 || rise_c[0] !== 2) $display("FAIL zero_first_rise: got cycle %0d required 2", (rise_c.size() == 0) ? -1 : rise_c[0]); else pass_cnt++;
  endtask

  // Fixed pattern with short timing; pulse widths and periods.
  task automatic test_pattern();
    int exp_hi [8];
    int bad_p;
    exp_hi[0] = 4; exp_hi[1] = 2; exp_hi[2] = 4; exp_hi[3] = 2;
    exp_hi[4] = 2; exp_hi[5] = 4; exp_hi[6] = 2; exp_hi[7] = 4;
    frames_b[0] = 24'hA500FF; frames_b[1] = 24'h000001;
    exp_frames[0] = 24'hA500FF; exp_frames[1] = 24'h000001;
    build_model(B_N, B_T0H, B_T1H, B_TBIT, B_TRES);
    run_refresh(1, B_N, B_TBIT, 1'b0, "pattern");
    total_cnt++;
    if (width_q.size() !== 48) $display("FAIL pattern_pulse_count: got %0d required 48", width_q.size()); else pass_cnt++;
    while (width_q.size() < 48) width_q.push_back(-1);
    for (int i = 0; i < 8; i++) begin
      total_cnt++;
      if (width_q[i] !== exp_hi[i]) $display("FAIL pattern_high_%0d: got %0d required %0d", i, width_q[i], exp_hi[i]); else pass_cnt++;
    end
    total_cnt++;
    if (width_q[47] !== 4) $display("FAIL pattern_last_high: got %0d required 4", width_q[47]); else pass_cnt++;
    bad_p = 0;
    for (int i = 1; i < rise_c.size(); i++) if (rise_c[i] - rise_c[i-1] != B_TBIT) bad_p++;
    total_cnt++;
    if (bad_p !== 0) $display("FAIL pattern_period: %0d periods not %0d (required 0)", bad_p, B_TBIT); else pass_cnt++;
  endtask

  // frame_in changes after LOAD of LED0 are ignored; LED1 gets its LOAD value.
  task automatic test_frame_change();
    logic [BITS-1:0] orig0, new1;
    orig0 = BITS'($urandom); new1 = BITS'($urandom);
    frames_b[0] = orig0; frames_b[1] = BITS'($urandom);
    exp_frames[0] = orig0; exp_frames[1] = new1;
    mut_c.push_back(30); mut_idx.push_back(0); mut_val.push_back(~orig0);
    mut_c.push_back(60); mut_idx.push_back(1); mut_val.push_back(new1);
    build_model(B_N, B_T0H, B_T1H, B_TBIT, B_TRES);
    run_refresh(1, B_N, B_TBIT, 1'b0, "frame_change");
    mut_c.delete(); mut_idx.delete(); mut_val.delete();
  endtask

  // start pulses while busy (HIGH, LOW, latch, done cycle) are ignored.
  task automatic test_ignored_start();
    int L;
    frames_b[0] = BITS'($urandom); frames_b[1] = BITS'($urandom);
    exp_frames[0] = frames_b[0]; exp_frames[1] = frames_b[1];
    build_model(B_N, B_T0H, B_T1H, B_TBIT, B_TRES);
    L = w.size();
    pulse_q.push_back(1); pulse_q.push_back(6); pulse_q.push_back(100);
    pulse_q.push_back(L - 3); pulse_q.push_back(L - 1);
    run_refresh(1, B_N, B_TBIT, 1'b0, "ignored_start");
    pulse_q.delete();
    total_cnt++;
    if (busy_cnt !== 1 + B_N * BITS * B_TBIT + B_TRES)
      $display("FAIL ignored_start_busy_cycles: got %0d required %0d", busy_cnt, 1 + B_N * BITS * B_TBIT + B_TRES);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (bus_b.busy !== 1'b0) $display("FAIL ignored_start_no_retrigger: busy got %b required 0", bus_b.busy); else pass_cnt++;
  endtask

  // Asynchronous reset mid-bit with the pin high, then a clean refresh.
  task automatic test_reset_mid();
    int target;
    target = BITS * B_TBIT + 2;
    frames_b[0] = BITS'($urandom); frames_b[1] = BITS'($urandom);
    exp_frames[0] = frames_b[0]; exp_frames[1] = frames_b[1];
    build_model(B_N, B_T0H, B_T1H, B_TBIT, B_TRES);
    bus_b.start = 1'b1;
    @(negedge clk);
    bus_b.start = 1'b0;
    repeat (target) @(negedge clk);
    total_cnt += 2;
    if (bus_b.dout !== 1'b1) $display("FAIL reset_mid_pre_dout: got %b required 1", bus_b.dout); else pass_cnt++;
    if (bus_b.led_idx !== 1'b1) $display("FAIL reset_mid_pre_led: got %0d required 1", bus_b.led_idx); else pass_cnt++;
    #1 rst = 1'b1;
    #1;
    total_cnt += 4;
    if (bus_b.dout !== 1'b0) $display("FAIL reset_mid_dout: got %b required 0", bus_b.dout); else pass_cnt++;
    if (bus_b.busy !== 1'b0) $display("FAIL reset_mid_busy: got %b required 0", bus_b.busy); else pass_cnt++;
    if (bus_b.led_idx !== 1'b0) $display("FAIL reset_mid_led_idx: got %0d required 0", bus_b.led_idx); else pass_cnt++;
    if (bus_b.done !== 1'b0) $display("FAIL reset_mid_done: got %b required 0", bus_b.done); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    run_refresh(1, B_N, B_TBIT, 1'b0, "after_reset");
  endtask

  // start held high: back-to-back refreshes with exactly one IDLE cycle.
  task automatic test_back_to_back();
    int d1;
    frames_b[0] = BITS'($urandom); frames_b[1] = BITS'($urandom);
    exp_frames[0] = frames_b[0]; exp_frames[1] = frames_b[1];
    build_model(B_N, B_T0H, B_T1H, B_TBIT, B_TRES);
    run_refresh(1, B_N, B_TBIT, 1'b1, "b2b_first");
    d1 = done_cyc;
    run_refresh(1, B_N, B_TBIT, 1'b1, "b2b_second");
    bus_b.start = 1'b0;
    total_cnt++;
    if (load_cyc - d1 !== 2) $display("FAIL b2b_gap: done to LOAD got %0d cycles required 2", load_cyc - d1); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (bus_b.busy !== 1'b0) $display("FAIL b2b_release: busy got %b required 0", bus_b.busy); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_default_zero();
    test_pattern();
    test_frame_change();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
